// File: rtl/change_dispenser.sv
// Coin payout controller: ejects $1, $0.50 and $0.25 coins one at a time,
// waiting for a drop-sensor acknowledge per coin, with timeout fault reporting.
module change_dispenser #(
  parameter int TIMEOUT_CYC = 255,
  parameter int GAP_CYC     = 4
) (
  input  logic        in_clka,
  input  logic        in_restart_n,
  input  logic        in_load,
  input  logic [7:0]  in_change_1,
  input  logic        in_change_05,
  input  logic        in_change_025,
  input  logic        in_sense,
  output logic        out_eject_1,
  output logic        out_eject_05,
  output logic        out_eject_025,
  output logic        out_busy,
  output logic        out_done,
  output logic        out_fault,
  output logic [7:0]  out_remaining_1,
  output logic [10:0] out_paid_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EJECT,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  // Ejector select is one-hot {$1, $0.50, $0.25}.
  localparam logic [2:0] SEL_1   = 3'b100;
  localparam logic [2:0] SEL_05  = 3'b010;
  localparam logic [2:0] SEL_025 = 3'b001;

  state_t      r_state,   w_state;
  logic [7:0]  r_cnt_1,   w_cnt_1;
  logic        r_pay_05,  w_pay_05;
  logic        r_pay_025, w_pay_025;
  logic [7:0]  r_tmo,     w_tmo;
  logic [3:0]  r_gap,     w_gap;
  logic [2:0]  r_eject,   w_eject;
  logic        r_busy,    w_busy;
  logic        r_done,    w_done;
  logic        r_fault,   w_fault;
  logic [10:0] r_paid,    w_paid;

  function automatic logic [2:0] pick(input logic [7:0] c1, input logic p05, input logic p025);
    logic [2:0] sel;
    sel = 3'b000;
    if (c1 != 8'd0)  sel = SEL_1;
    else if (p05)    sel = SEL_05;
    else if (p025)   sel = SEL_025;
    return sel;
  endfunction

  always_comb begin
    // NOTE: every next value starts from a hold/idle default so no branch can infer a latch.
    w_state   = r_state;
    w_cnt_1   = r_cnt_1;
    w_pay_05  = r_pay_05;
    w_pay_025 = r_pay_025;
    w_tmo     = r_tmo;
    w_gap     = r_gap;
    w_eject   = 3'b000;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_fault   = r_fault;
    w_paid    = r_paid;

    case (r_state)
      S_IDLE, S_FAULT: begin
        if (in_load) begin
          w_cnt_1   = in_change_1;
          w_pay_05  = in_change_05;
          w_pay_025 = in_change_025;
          w_paid    = '0;
          w_fault   = 1'b0;
          w_tmo     = '0;
          if ((in_change_1 != 8'd0) || in_change_05 || in_change_025) begin
            w_state = S_EJECT;
            w_eject = pick(in_change_1, in_change_05, in_change_025);
            w_busy  = 1'b1;
          end else begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end
        end
      end

      S_EJECT: begin
        w_busy = 1'b1;
        // A sense in the final timeout cycle still counts the coin.
        if (in_sense) begin
          if (r_eject == SEL_1) begin
            w_cnt_1 = r_cnt_1 - 8'd1;
            w_paid  = r_paid + 11'd4;
          end else if (r_eject == SEL_05) begin
            w_pay_05 = 1'b0;
            w_paid   = r_paid + 11'd2;
          end else begin
            w_pay_025 = 1'b0;
            w_paid    = r_paid + 11'd1;
          end
          w_tmo   = '0;
          w_gap   = '0;
          w_state = S_GAP;
        end else if (r_tmo == TMO_LAST) begin
          w_state = S_FAULT;
          w_fault = 1'b1;
          w_busy  = 1'b0;
        end else begin
          w_tmo   = r_tmo + 8'd1;
          w_eject = r_eject;
        end
      end

      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          if ((r_cnt_1 != 8'd0) || r_pay_05 || r_pay_025) begin
            w_state = S_EJECT;
            w_eject = pick(r_cnt_1, r_pay_05, r_pay_025);
            w_busy  = 1'b1;
          end else begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end
        end else begin
          w_gap  = r_gap + 4'd1;
          w_busy = 1'b1;
        end
      end

      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge in_clka or negedge in_restart_n) begin
    if (!in_restart_n) begin
      r_state   <= S_IDLE;
      r_cnt_1   <= '0;
      r_pay_05  <= 1'b0;
      r_pay_025 <= 1'b0;
      r_tmo     <= '0;
      r_gap     <= '0;
      r_eject   <= 3'b000;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fault   <= 1'b0;
      r_paid    <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt_1   <= w_cnt_1;
      r_pay_05  <= w_pay_05;
      r_pay_025 <= w_pay_025;
      r_tmo     <= w_tmo;
      r_gap     <= w_gap;
      r_eject   <= w_eject;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_fault   <= w_fault;
      r_paid    <= w_paid;
    end
  end

  assign out_eject_1     = r_eject[2];
  assign out_eject_05    = r_eject[1];
  assign out_eject_025   = r_eject[0];
  assign out_busy        = r_busy;
  assign out_done        = r_done;
  assign out_fault       = r_fault;
  assign out_remaining_1 = r_cnt_1;
  assign out_paid_q      = r_paid;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a job-level model queues the expected
// event sequence, a negedge monitor pops and compares as the DUT produces events.
module tb_change_dispenser;
  localparam int TIMEOUT_CYC = 255;
  localparam int GAP_CYC     = 4;

  typedef enum int {EV_VAL, EV_RISE, EV_DONE, EV_FAULT} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [2:0] ej;
    int         rem;
    int         paid;
  } ev_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        load  = 1'b0;
  logic [7:0]  ch1   = 8'd0;
  logic        ch05  = 1'b0;
  logic        ch025 = 1'b0;
  logic        sense = 1'b0;
  logic        ej1, ej05, ej025, busy, done, fault;
  logic [7:0]  rem;
  logic [10:0] paid;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  exp_rem  = 0;
  int  exp_paid = 0;

  always #5 clk = ~clk;

  change_dispenser #(.TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut (
    .in_clka        (clk),
    .in_restart_n   (rst_n),
    .in_load        (load),
    .in_change_1    (ch1),
    .in_change_05   (ch05),
    .in_change_025  (ch025),
    .in_sense       (sense),
    .out_eject_1    (ej1),
    .out_eject_05   (ej05),
    .out_eject_025  (ej025),
    .out_busy       (busy),
    .out_done       (done),
    .out_fault      (fault),
    .out_remaining_1(rem),
    .out_paid_q     (paid)
  );

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    check(act == exp, name, act, exp);
  endtask

  function automatic ev_t mk(input ev_kind_t k, input logic [2:0] e, input int r, input int p);
    ev_t x;
    x.kind = k;
    x.ej   = e;
    x.rem  = r;
    x.paid = p;
    return x;
  endfunction

  // Job model: expand the change into a coin list, then walk it.
  task automatic model_job(input int c1, input bit f05, input bit f025, input int fault_idx);
    int coins[$];
    int r, p;
    for (int i = 0; i < c1; i++) coins.push_back(4);
    if (f05)  coins.push_back(2);
    if (f025) coins.push_back(1);
    r = c1;
    p = 0;
    if (r != exp_rem || p != exp_paid) sb.push_back(mk(EV_VAL, 3'b000, r, p));
    foreach (coins[i]) begin
      sb.push_back(mk(EV_RISE, (coins[i] == 4) ? 3'b100 : (coins[i] == 2) ? 3'b010 : 3'b001, 0, 0));
      if (i == fault_idx) begin
        sb.push_back(mk(EV_FAULT, 3'b000, r, p));
        exp_rem  = r;
        exp_paid = p;
        return;
      end
      p += coins[i];
      if (coins[i] == 4) r--;
      sb.push_back(mk(EV_VAL, 3'b000, r, p));
    end
    sb.push_back(mk(EV_DONE, 3'b000, r, p));
    exp_rem  = r;
    exp_paid = p;
  endtask

  task automatic pop_expect(input ev_kind_t k, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = mk(EV_VAL, 3'b000, 0, 0);
    check(sb.size() > 0, $sformatf("unexpected_event_kind%0d", int'(k)), sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("event_kind", int'(e.kind), int'(k));
      ok = (e.kind == k);
    end
  endtask

  logic [2:0] prev_ej    = 3'b000;
  int         prev_rem   = 0;
  int         prev_paid  = 0;
  logic       prev_done  = 1'b0;
  logic       prev_fault = 1'b0;

  always @(negedge clk) begin : monitor
    logic [2:0] cur_ej;
    ev_t        e;
    bit         ok;
    cur_ej = {ej1, ej05, ej025};
    if (rst_n) begin
      if (cur_ej != 3'b000) check_eq("eject_onehot", $countones(cur_ej), 1);
      if (int'(rem) != prev_rem || int'(paid) != prev_paid) begin
        pop_expect(EV_VAL, e, ok);
        if (ok) begin
          check_eq("val_remaining_1", int'(rem), e.rem);
          check_eq("val_paid_q", int'(paid), e.paid);
        end
      end
      if (cur_ej != 3'b000 && prev_ej == 3'b000) begin
        pop_expect(EV_RISE, e, ok);
        if (ok) check_eq("rise_ejector", int'(cur_ej), int'(e.ej));
      end
      if (done && !prev_done) begin
        pop_expect(EV_DONE, e, ok);
        if (ok) check_eq("done_paid_q", int'(paid), e.paid);
      end
      if (fault && !prev_fault) begin
        pop_expect(EV_FAULT, e, ok);
        if (ok) begin
          check_eq("fault_remaining_1", int'(rem), e.rem);
          check_eq("fault_paid_q", int'(paid), e.paid);
        end
      end
    end
    prev_ej    = cur_ej;
    prev_rem   = int'(rem);
    prev_paid  = int'(paid);
    prev_done  = done;
    prev_fault = fault;
  end

  // fixed_dly < 0 picks a random sense delay per coin; glitch pulses load=9 in each gap.
  task automatic run_job(input int c1, input bit f05, input bit f025, input int fault_idx,
                         input int fixed_dly, input bit glitch);
    int total, n, dly, hold;
    total = c1 + int'(f05) + int'(f025);
    model_job(c1, f05, f025, fault_idx);
    @(negedge clk);
    load  = 1'b1;
    ch1   = 8'(c1);
    ch05  = f05;
    ch025 = f025;
    @(negedge clk);
    load  = 1'b0;
    ch1   = 8'd0;
    ch05  = 1'b0;
    ch025 = 1'b0;
    if (total == 0) begin
      check_eq("zero_done", int'(done), 1);
      check_eq("zero_busy", int'(busy), 0);
      check_eq("zero_eject", int'({ej1, ej05, ej025}), 0);
      @(negedge clk);
      check_eq("zero_done_width", int'(done), 0);
      return;
    end
    check_eq("load_busy", int'(busy), 1);
    for (int i = 0; i < total; i++) begin
      if (i == fault_idx) begin
        n = 1;
        while (n <= TIMEOUT_CYC + 4) begin
          @(negedge clk);
          if ({ej1, ej05, ej025} == 3'b000) break;
          n++;
        end
        check_eq("eject_high_cycles", n, TIMEOUT_CYC);
        check_eq("fault_flag", int'(fault), 1);
        check_eq("fault_busy", int'(busy), 0);
        return;
      end
      dly  = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 8));
      hold = int'($urandom_range(1, 3));
      repeat (dly) @(negedge clk);
      sense = 1'b1;
      n = 0;
      while (n < GAP_CYC + 4) begin
        @(negedge clk);
        n++;
        if (n == hold) sense = 1'b0;
        load = glitch && (n == 2);
        ch1  = load ? 8'd9 : 8'd0;
        if (n == 1) check_eq("eject_drop", int'({ej1, ej05, ej025}), 0);
        if ({ej1, ej05, ej025} != 3'b000 || done) break;
      end
      sense = 1'b0;
      load  = 1'b0;
      ch1   = 8'd0;
      check_eq("gap_length", n, GAP_CYC + 1);
      if (i == total - 1) begin
        check_eq("done_pulse", int'(done), 1);
        check_eq("done_busy", int'(busy), 0);
        @(negedge clk);
        check_eq("done_width", int'(done), 0);
      end else begin
        check_eq("next_eject_busy", int'(busy), 1);
      end
    end
  endtask

  task automatic pulse_sense_idle();
    @(negedge clk);
    sense = 1'b1;
    repeat (2) @(negedge clk);
    sense = 1'b0;
    @(negedge clk);
    check_eq("idle_sense_paid_q", int'(paid), exp_paid);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, actual %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int c1, total, fidx;
    bit f05, f025;

    repeat (3) @(negedge clk);
    check_eq("reset_outputs", int'({ej1, ej05, ej025, busy, done, fault, rem, paid}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal payout: 2 x $1 + $0.50, sense 3 cycles after each rise.
    run_job(2, 1'b1, 1'b0, -1, 3, 1'b0);
    check_eq("normal_paid_q", int'(paid), 10);
    check_eq("normal_remaining_1", int'(rem), 0);
    pulse_sense_idle();

    // Zero change.
    run_job(0, 1'b0, 1'b0, -1, -1, 1'b0);

    // Timeout on a lone $0.25, then a recovering job.
    run_job(0, 1'b0, 1'b1, 0, -1, 1'b0);
    check_eq("timeout_paid_q", int'(paid), 0);
    pulse_sense_idle();
    run_job(1, 1'b0, 1'b0, -1, -1, 1'b0);
    check_eq("recover_fault", int'(fault), 0);
    check_eq("recover_paid_q", int'(paid), 4);

    // Sense in the last allowed EJECT cycle.
    run_job(0, 1'b0, 1'b1, -1, TIMEOUT_CYC - 1, 1'b0);
    check_eq("race_no_fault", int'(fault), 0);
    check_eq("race_paid_q", int'(paid), 1);

    // Loads pulsed during GAP are ignored.
    run_job(3, 1'b1, 1'b1, -1, -1, 1'b1);
    check_eq("glitch_paid_q", int'(paid), 15);

    // Reset in the second cycle of an ejection.
    model_job(3, 1'b0, 1'b0, -1);
    @(negedge clk);
    load = 1'b1;
    ch1  = 8'd3;
    @(negedge clk);
    load = 1'b0;
    ch1  = 8'd0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midjob_reset_outputs", int'({ej1, ej05, ej025, busy, done, fault, rem, paid}), 0);
    sb.delete();
    exp_rem  = 0;
    exp_paid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_job(2, 1'b1, 1'b1, -1, -1, 1'b0);
    check_eq("after_reset_paid_q", int'(paid), 11);

    // Maximum payout value.
    run_job(255, 1'b1, 1'b1, -1, -1, 1'b0);
    check_eq("max_paid_q", int'(paid), 1023);

    // Randomized jobs, occasional faults and idle sense pulses.
    for (int j = 0; j < 30; j++) begin
      c1    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 4));
      f05   = 1'($urandom_range(0, 1));
      f025  = 1'($urandom_range(0, 1));
      total = c1 + int'(f05) + int'(f025);
      fidx  = (total > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, total - 1)) : -1;
      run_job(c1, f05, f025, fidx, -1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) pulse_sense_idle();
    end

    repeat (5) @(negedge clk);
    check_eq("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
